// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: RFC8439 constants, the unpacker state type and
// the byte-order helper used by the stream engine and its width converters.
package chacha_pkg;

    localparam logic [31:0] CHACHA_C0 = 32'h61707865;
    localparam logic [31:0] CHACHA_C1 = 32'h3320646e;
    localparam logic [31:0] CHACHA_C2 = 32'h79622d32;
    localparam logic [31:0] CHACHA_C3 = 32'h6b206574;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } unpack_state_e;

    // Byte 0 sits in the MSBs; returns the LSB position of byte byte_idx in a width-bit word.
    function automatic int byte_lsb(input int byte_idx, input int width);
        return width - 8 * (byte_idx + 1);
    endfunction

endpackage

// File: rtl/chacha_stream_unpacker.sv
// Serializes IN_W-bit engine blocks into OUT_W-bit beats, byte 0 first, trimming
// trailing empty beats of a TLAST block so TKEEP is exact at message end.
module chacha_stream_unpacker
    import chacha_pkg::*;
#(
    parameter int IN_W  = 512,
    parameter int OUT_W = 128
) (
    input  logic                 aclk,
    input  logic                 srst,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    input  logic [IN_W-1:0]      i_tdata,
    input  logic [IN_W/8-1:0]    i_tkeep,
    input  logic                 i_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [OUT_W-1:0]     o_tdata,
    output logic [OUT_W/8-1:0]   o_tkeep,
    output logic                 o_tlast
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int IN_B  = IN_W / 8;
    localparam int OUT_B = OUT_W / 8;
    localparam int IDX_W = $clog2(RATIO);

    unpack_state_e     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic [IDX_W-1:0]  last_idx_d;
    logic [IN_W-1:0]   hold_data_q;
    logic [IN_B-1:0]   hold_keep_q;
    logic              hold_last_q;

    logic [OUT_W-1:0]  beat_data [RATIO];
    logic [OUT_B-1:0]  beat_keep [RATIO];
    logic [RATIO-1:0]  in_keep_nz;

    logic              at_last;
    logic              accept;
    logic              beat_hs;

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            // Beat gi ends with byte (gi+1)*OUT_B-1, which is its lowest-addressed bit.
            localparam int DLSB = byte_lsb((gi + 1) * OUT_B - 1, IN_W);
            localparam int KLSB = IN_B - (gi + 1) * OUT_B;
            assign beat_data[gi]  = hold_data_q[DLSB +: OUT_W];
            assign beat_keep[gi]  = hold_keep_q[KLSB +: OUT_B];
            assign in_keep_nz[gi] = |i_tkeep[KLSB +: OUT_B];
        end
    endgenerate

    // Highest beat with any kept byte wins; an all-zero last block still gets beat 0.
    always_comb begin
        last_idx_d = i_tlast ? '0 : IDX_W'(RATIO - 1);
        if (i_tlast) begin
            for (int k = 0; k < RATIO; k++) begin
                if (in_keep_nz[k]) begin
                    last_idx_d = IDX_W'(k);
                end
            end
        end
    end

    assign at_last  = (idx_q == last_idx_q);
    assign i_tready = !srst && ((state_q == ST_EMPTY) || (o_tready && at_last));
    assign accept   = i_tvalid && i_tready;
    assign beat_hs  = (state_q == ST_DRAIN) && o_tready;

    assign o_tvalid = (state_q == ST_DRAIN);
    assign o_tdata  = beat_data[idx_q];
    assign o_tkeep  = beat_keep[idx_q];
    assign o_tlast  = hold_last_q && at_last;

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q     <= ST_EMPTY;
            idx_q       <= '0;
            last_idx_q  <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
        end else if (accept) begin
            // Covers both the idle load and the reload on the final beat of a block.
            state_q     <= ST_DRAIN;
            idx_q       <= '0;
            last_idx_q  <= last_idx_d;
            hold_data_q <= i_tdata;
            hold_keep_q <= i_tkeep;
            hold_last_q <= i_tlast;
        end else if (beat_hs) begin
            if (at_last) begin
                state_q <= ST_EMPTY;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chacha_stream_unpacker.sv
// Directed and randomized-length checks of the block-to-beat unpacker.
module tb_chacha_stream_unpacker;

    localparam int IN_W  = 512;
    localparam int OUT_W = 128;
    localparam int RATIO = IN_W / OUT_W;

    logic               aclk;
    logic               srst;
    logic               i_tvalid;
    logic               i_tready;
    logic [IN_W-1:0]    i_tdata;
    logic [IN_W/8-1:0]  i_tkeep;
    logic               i_tlast;
    logic               o_tvalid;
    logic               o_tready;
    logic [OUT_W-1:0]   o_tdata;
    logic [OUT_W/8-1:0] o_tkeep;
    logic               o_tlast;

    chacha_stream_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .aclk     (aclk),
        .srst     (srst),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .i_tdata  (i_tdata),
        .i_tkeep  (i_tkeep),
        .i_tlast  (i_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } blk_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    typedef struct {
        logic [63:0] keep;
        logic        last;
        int          exp_beats;
        logic [15:0] exp_fkeep;
        logic        exp_flast;
    } vec_t;

    blk_t  in_q[$];
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int           beats_seen;
    int           tlast_count;
    int           first_acc_cyc;
    int           first_hs_cyc;
    int           last_hs_cyc;
    logic [127:0] first_beat_data;
    logic [15:0]  last_beat_keep;
    logic         last_beat_last;
    logic         tready_at_last;

    logic [511:0] seq_data;
    vec_t         vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic void model_push(input blk_t b);
        int nb;
        beat_t t;
        nb = b.last ? 1 : RATIO;
        if (b.last) begin
            for (int k = 0; k < RATIO; k++) begin
                if (|b.keep[63-16*k -: 16]) nb = k + 1;
            end
        end
        for (int k = 0; k < nb; k++) begin
            t.data = b.data[511-128*k -: 128];
            t.keep = b.keep[63-16*k -: 16];
            t.last = b.last && (k == nb - 1);
            exp_q.push_back(t);
        end
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
        return d;
    endfunction

    // Streams in_q through the DUT, comparing every output beat against the model.
    task automatic run_blocks(input bit rand_ready);
        int           cyc;
        bit           prev_stall;
        logic [127:0] pd;
        logic [15:0]  pk;
        logic         pl;
        beat_t        e;
        cyc = 0; prev_stall = 0; pd = '0; pk = '0; pl = 1'b0;
        beats_seen = 0; tlast_count = 0; first_acc_cyc = -1; first_hs_cyc = -1;
        last_hs_cyc = -1; first_beat_data = '0; last_beat_keep = '0;
        last_beat_last = 1'b0; tready_at_last = 1'b0;
        while (1) begin
            @(posedge aclk);
            #1;
            cyc++;
            if (in_q.size() > 0) begin
                i_tvalid = 1'b1;
                i_tdata  = in_q[0].data;
                i_tkeep  = in_q[0].keep;
                i_tlast  = in_q[0].last;
            end else begin
                i_tvalid = 1'b0;
            end
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_valid", o_tvalid, 1'b1);
                chk("stall_data", o_tdata, pd);
                chk("stall_keep", o_tkeep, pk);
                chk("stall_last", o_tlast, pl);
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", o_tvalid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", o_tdata, e.data);
                    chk("beat_keep", o_tkeep, e.keep);
                    chk("beat_last", o_tlast, e.last);
                end
                if (beats_seen == 0) begin
                    first_hs_cyc    = cyc;
                    first_beat_data = o_tdata;
                end
                beats_seen++;
                last_hs_cyc    = cyc;
                last_beat_keep = o_tkeep;
                last_beat_last = o_tlast;
                if (o_tlast) begin
                    tlast_count++;
                    tready_at_last = i_tready;
                end
            end
            if (i_tvalid && i_tready) begin
                $display("block in: keep=%016h last=%0b cycle=%0d", in_q[0].keep, in_q[0].last, cyc);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                model_push(in_q[0]);
                void'(in_q.pop_front());
            end
            prev_stall = o_tvalid && !o_tready;
            pd = o_tdata; pk = o_tkeep; pl = o_tlast;
            if (in_q.size() == 0 && exp_q.size() == 0) break;
            if (cyc > 5000) begin
                chk("run_timeout", 128'(exp_q.size() + in_q.size()), '0);
                in_q.delete();
                exp_q.delete();
                break;
            end
        end
        step();
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        #1;
        chk("idle_after_run", o_tvalid, 1'b0);
    endtask

    initial begin
        for (int b = 0; b < 64; b++) seq_data[511-8*b -: 8] = 8'(b);

        vecs[0] = '{keep: 64'hFFFFFFFF_FFFFFFFF, last: 1'b1, exp_beats: 4, exp_fkeep: 16'hFFFF, exp_flast: 1'b1};
        vecs[1] = '{keep: 64'hFFFFF000_00000000, last: 1'b1, exp_beats: 2, exp_fkeep: 16'hF000, exp_flast: 1'b1};
        vecs[2] = '{keep: 64'h00000000_00000000, last: 1'b1, exp_beats: 1, exp_fkeep: 16'h0000, exp_flast: 1'b1};
        vecs[3] = '{keep: 64'h00000000_00000001, last: 1'b1, exp_beats: 4, exp_fkeep: 16'h0001, exp_flast: 1'b1};
        vecs[4] = '{keep: 64'h0000FFFF_00000000, last: 1'b1, exp_beats: 2, exp_fkeep: 16'hFFFF, exp_flast: 1'b1};
        vecs[5] = '{keep: 64'h00000000_00000000, last: 1'b0, exp_beats: 4, exp_fkeep: 16'h0000, exp_flast: 1'b0};

        srst = 1'b1; i_tvalid = 1'b0; i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0; o_tready = 1'b0;
        repeat (3) step();
        chk("rst_i_tready", i_tready, 1'b0);
        chk("rst_o_tvalid", o_tvalid, 1'b0);
        chk("rst_o_tlast", o_tlast, 1'b0);
        chk("rst_o_tkeep", o_tkeep, '0);
        chk("rst_o_tdata", o_tdata, '0);
        srst = 1'b0;
        #1;
        chk("rst_release_tready", i_tready, 1'b1);

        for (int v = 0; v < 6; v++) begin
            in_q.push_back('{data: seq_data, keep: vecs[v].keep, last: vecs[v].last});
            run_blocks(1'b0);
            chk($sformatf("vec%0d_beats", v), 128'(beats_seen), 128'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_final_keep", v), last_beat_keep, vecs[v].exp_fkeep);
            chk($sformatf("vec%0d_final_last", v), last_beat_last, vecs[v].exp_flast);
            chk($sformatf("vec%0d_latency", v), 128'(first_hs_cyc - first_acc_cyc), 128'd1);
            chk($sformatf("vec%0d_no_bubble", v), 128'(last_hs_cyc - first_hs_cyc + 1), 128'(vecs[v].exp_beats));
            if (v == 0) begin
                chk("vec0_beat0_data", first_beat_data, 128'h000102030405060708090A0B0C0D0E0F);
                chk("vec0_tready_on_beat3", tready_at_last, 1'b1);
                chk("vec0_tlast_count", 128'(tlast_count), 128'd1);
            end
        end

        for (int j = 0; j < 3; j++) in_q.push_back('{data: rand_data(), keep: '1, last: (j == 2)});
        run_blocks(1'b0);
        chk("b2b_beats", 128'(beats_seen), 128'd12);
        chk("b2b_no_bubble", 128'(last_hs_cyc - first_hs_cyc + 1), 128'd12);
        chk("b2b_tlast_count", 128'(tlast_count), 128'd1);
        chk("b2b_final_last", last_beat_last, 1'b1);

        begin
            int nblk;
            int len;
            int nb;
            int rem;
            logic [63:0] ones;
            blk_t b;
            ones = '1;
            nblk = 0;
            while (nblk < 100) begin
                len = $urandom_range(0, 200);
                nb  = (len == 0) ? 1 : (len + 63) / 64;
                for (int j = 0; j < nb; j++) begin
                    rem    = len - 64 * j;
                    b.data = rand_data();
                    b.last = (j == nb - 1);
                    b.keep = !b.last ? ones : (rem >= 64 ? ones : ~(ones >> rem));
                    in_q.push_back(b);
                end
                nblk += nb;
            end
            run_blocks(1'b1);
        end

        step();
        i_tvalid = 1'b1; i_tdata = seq_data; i_tkeep = '1; i_tlast = 1'b1; o_tready = 1'b1;
        #1;
        chk("rstseq_accept", i_tready, 1'b1);
        step();
        i_tvalid = 1'b0;
        #1;
        chk("rstseq_beat0", o_tdata, seq_data[511:384]);
        step();
        #1;
        chk("rstseq_beat1", o_tdata, seq_data[383:256]);
        step();
        o_tready = 1'b0;
        #1;
        chk("rstseq_beat2_valid", o_tvalid, 1'b1);
        chk("rstseq_beat2", o_tdata, seq_data[255:128]);
        step();
        srst = 1'b1;
        #1;
        chk("rstseq_tready_in_rst", i_tready, 1'b0);
        chk("rstseq_held_before_edge", o_tdata, seq_data[255:128]);
        step();
        srst = 1'b0;
        #1;
        chk("rstseq_valid_dropped", o_tvalid, 1'b0);
        chk("rstseq_data_cleared", o_tdata, '0);
        chk("rstseq_last_cleared", o_tlast, 1'b0);
        step();
        o_tready = 1'b1;
        #1;
        chk("rstseq_no_residual", o_tvalid, 1'b0);
        begin
            blk_t nb_blk;
            nb_blk.data = rand_data();
            nb_blk.keep = '1;
            nb_blk.last = 1'b1;
            in_q.push_back(nb_blk);
            run_blocks(1'b0);
            chk("rstseq_next_beat0", first_beat_data, nb_blk.data[511:384]);
            chk("rstseq_next_beats", 128'(beats_seen), 128'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
